// File: rtl/ppg_pkg.sv
//------------------------------------------------------------------------------
// Module      : ppg_pkg
// Description : Shared types and constants for the PPG timing path.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package ppg_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FRAME = 2'd1,
    FLUSH = 2'd2,
    LINE  = 2'd3
  } ppg_state_t;

  // Two cycles keeps successive line triggers distinct at the ppg_unit counter
  localparam int unsigned PPG_MIN_TLINE = 2;

endpackage

`default_nettype wire

// File: rtl/ppg_seq_timer.sv
//------------------------------------------------------------------------------
// Module      : ppg_seq_timer
// Description : Loadable down-counter with a terminal-count (zero) flag.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module ppg_seq_timer #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic             i_en,
  input  logic [WIDTH-1:0] i_value,
  output logic             o_tc
);

  logic [WIDTH-1:0] r_count;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_value;
    end else if (i_en && (r_count != '0)) begin
      r_count <= r_count - WIDTH'(1);
    end
  end

  assign o_tc = (r_count == '0);

endmodule

`default_nettype wire

// File: rtl/ppg_frame_seq.sv
//------------------------------------------------------------------------------
// Module      : ppg_frame_seq
// Description : Frame/line trigger sequencer feeding the ppg_unit pulse gens.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module ppg_frame_seq
  import ppg_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int LWIDTH = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [WIDTH-1:0]  cfg_tflush,
  input  logic [WIDTH-1:0]  cfg_tline,
  input  logic [LWIDTH-1:0] cfg_nlines,
  output logic              busy,
  output logic              done,
  output logic              frame_trig,
  output logic              line_trig,
  output logic [LWIDTH-1:0] line_idx
);

  localparam logic [WIDTH-1:0] c_min_tline = WIDTH'(PPG_MIN_TLINE);

  ppg_state_t        r_state;
  ppg_state_t        w_state_nxt;

  logic [WIDTH-1:0]  r_tflush;
  logic [WIDTH-1:0]  r_tline;
  logic [LWIDTH-1:0] r_nlines;
  logic [LWIDTH-1:0] r_line_idx;

  logic              r_busy;
  logic              r_done;
  logic              r_frame_trig;
  logic              r_line_trig;

  logic              w_accept;
  logic              w_flush_load;
  logic              w_flush_en;
  logic              w_flush_tc;
  logic              w_line_load;
  logic              w_line_en;
  logic              w_line_tc;
  logic              w_line_inc;
  logic              w_done_nxt;
  logic [WIDTH-1:0]  w_tline_clamped;
  logic              w_last_line;

  assign w_tline_clamped = (cfg_tline < c_min_tline) ? c_min_tline : cfg_tline;
  assign w_last_line     = (r_line_idx == (r_nlines - LWIDTH'(1)));

  ppg_seq_timer #(.WIDTH(WIDTH)) u_flush_timer (
    .clk     (clk),
    .rst     (rst),
    .i_load  (w_flush_load),
    .i_en    (w_flush_en),
    .i_value (r_tflush - WIDTH'(1)),
    .o_tc    (w_flush_tc)
  );

  // Loaded with tline-1 on every line start, so the load cycle marks phase 0
  ppg_seq_timer #(.WIDTH(WIDTH)) u_line_timer (
    .clk     (clk),
    .rst     (rst),
    .i_load  (w_line_load),
    .i_en    (w_line_en),
    .i_value (r_tline - WIDTH'(1)),
    .o_tc    (w_line_tc)
  );

  always_comb begin
    w_state_nxt  = r_state;
    w_accept     = 1'b0;
    w_flush_load = 1'b0;
    w_flush_en   = 1'b0;
    w_line_load  = 1'b0;
    w_line_en    = 1'b0;
    w_line_inc   = 1'b0;
    w_done_nxt   = 1'b0;
    case (r_state)
      IDLE: begin
        if (start && !abort) begin
          w_accept    = 1'b1;
          w_state_nxt = FRAME;
        end
      end
      FRAME: begin
        if (abort) begin
          w_state_nxt = IDLE;
        end else if (r_tflush != '0) begin
          w_state_nxt  = FLUSH;
          w_flush_load = 1'b1;
        end else if (r_nlines == '0) begin
          w_state_nxt = IDLE;
          w_done_nxt  = 1'b1;
        end else begin
          w_state_nxt = LINE;
          w_line_load = 1'b1;
        end
      end
      FLUSH: begin
        if (abort) begin
          w_state_nxt = IDLE;
        end else if (w_flush_tc) begin
          if (r_nlines == '0) begin
            w_state_nxt = IDLE;
            w_done_nxt  = 1'b1;
          end else begin
            w_state_nxt = LINE;
            w_line_load = 1'b1;
          end
        end else begin
          w_flush_en = 1'b1;
        end
      end
      LINE: begin
        if (abort) begin
          w_state_nxt = IDLE;
        end else if (w_line_tc) begin
          if (w_last_line) begin
            w_state_nxt = IDLE;
            w_done_nxt  = 1'b1;
          end else begin
            w_line_load = 1'b1;
            w_line_inc  = 1'b1;
          end
        end else begin
          w_line_en = 1'b1;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_tflush     <= '0;
      r_tline      <= '0;
      r_nlines     <= '0;
      r_line_idx   <= '0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_frame_trig <= 1'b0;
      r_line_trig  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_tflush <= cfg_tflush;
        r_tline  <= w_tline_clamped;
        r_nlines <= cfg_nlines;
      end
      if (w_state_nxt == IDLE) begin
        r_line_idx <= '0;
      end else if (w_line_inc) begin
        r_line_idx <= r_line_idx + LWIDTH'(1);
      end
      r_busy       <= (w_state_nxt != IDLE);
      r_done       <= w_done_nxt;
      r_frame_trig <= (w_state_nxt == FRAME);
      r_line_trig  <= w_line_load;
    end
  end

  assign busy       = r_busy;
  assign done       = r_done;
  assign frame_trig = r_frame_trig;
  assign line_trig  = r_line_trig;
  assign line_idx   = r_line_idx;

endmodule

`default_nettype wire

// File: doc/ppg_frame_seq.md
# ppg_frame_seq

Frame/line trigger sequencer that sits directly upstream of the `ppg_unit` pulse generators in the sensor timing path. On a start request it latches a frame configuration, then emits a frame marker, a flush interval and a train of evenly spaced single-cycle line triggers. Each line trigger drives the `trig` input of the per-line `ppg_unit` instances. It reports busy/done so the control plane can chain frames.

## Interface
- `WIDTH`, 16: cycle-timer width; matches `ppg_unit` `WIDTH`.
- `LWIDTH`, 12: line-counter width.

- `clk`  in  1  system clock; the only clock.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  frame request; sampled every cycle, accepted only when `busy`=0.
- `abort`  in  1  terminates the frame in progress.
- `cfg_tflush`  in  WIDTH  flush-interval length in cycles; 0 is allowed.
- `cfg_tline`  in  WIDTH  line period in cycles; values below 2 are clamped to 2.
- `cfg_nlines`  in  LWIDTH  lines per frame; 0 is allowed.
- `busy`  out  1  frame in progress.
- `done`  out  1  one-cycle pulse at normal frame completion.
- `frame_trig`  out  1  one-cycle frame-start marker.
- `line_trig`  out  1  one-cycle line trigger, connected to `ppg_unit.trig`.
- `line_idx`  out  LWIDTH  index of the current line.

## Operation
- States: IDLE, FRAME, FLUSH, LINE.
- IDLE:
  - `start`=1 and `abort`=0 → latch `cfg_*` into shadow registers, applying the `cfg_tline` clamp, then go to FRAME.
- FRAME: lasts one cycle.
  - `frame_trig`=1.
  - Next state is FLUSH if tflush>0, otherwise LINE.
- FLUSH: lasts tflush cycles, then goes to LINE.
- LINE:
  - When nlines=0, LINE lasts zero cycles: `done` pulses on the cycle following FLUSH (or FRAME), and the block is in IDLE that cycle.
  - Otherwise a phase timer runs 0..tline-1.
  - `line_trig`=1 when phase=0.
  - `line_idx` increments when the phase wraps from tline-1 to 0.
  - After line nlines-1 completes: `done`=1 for one cycle, state IDLE.
- `done` and `busy` are never both 1.
- `start` is honoured on the `done` cycle, which gives back-to-back frames.
- `start` while `busy`=1 is ignored; no queueing.
- `cfg_*` changes while busy are ignored; the latched values are used for the whole frame.
- `abort` while busy:
  - Next cycle: state IDLE, all outputs 0, no `done`.
  - Any `ppg_unit` pulse already triggered runs to completion.
- `abort` and `start` together in IDLE: `start` is ignored.
- `rst` at any time: state IDLE, shadow registers cleared; takes priority over everything.
- `line_idx` is 0 in IDLE and holds the last index for the remainder of its line.
- Arithmetic:
  - Phase and flush timers are WIDTH bits wide; the line counter is LWIDTH bits wide.
  - No wrap-around is possible because each terminal count is compared against the latched value.

## Timing
- Reset values: `busy`, `done`, `frame_trig`, `line_trig` = 0; `line_idx` = 0.
- All outputs are registered; none is combinational from any input.
- `start` is sampled at edge T:
  - `frame_trig` and `busy` rise at T+1.
  - Line k trigger: T+2+F+k·L, for k=0..N-1.
  - `done`: T+2+F+N·L; `busy` falls the same cycle.
- `busy` is high for exactly 1+F+N·L cycles, and at least 1.
- `abort` sampled at edge A → at A+1: `busy`=0, `line_trig`=0; no later triggers.
- Minimum `line_trig` spacing is 2 cycles. This guarantees that `ppg_unit`'s counter sees distinct triggers.

## Structure
- Package `ppg_pkg`: state enum (IDLE/FRAME/FLUSH/LINE) and constant `PPG_MIN_TLINE`=2. `ppg_unit` shares this package in future.
- One sub-module, `ppg_seq_timer`: a loadable WIDTH-bit down-counter with a terminal-count flag. It is instantiated twice, once for the flush interval and once for the line phase.
- The FSM, shadow registers and line counter live in the top module.

## Test plan
- F=3, L=5, N=4, `start` at edge 10:
  - `frame_trig`@11; `line_trig`@15,20,25,30.
  - `line_idx` 0,1,2,3; `done`@35; `busy` high cycles 11–34.
- F=0, N=0, `start`@10 → `frame_trig`@11, `done`@12, no `line_trig`.
- F=0, L=1 (clamped to 2), N=3, `start`@10 → `line_trig`@12,14,16; `done`@18.
- Same config as the first case, `abort`@22 → `busy`=0@23, no `line_trig`@25, no `done`. `start`@25 → `frame_trig`@26.
- Start and config edge cases:
  - `start` pulsed and `cfg_tline` changed to 9 mid-frame → ignored; spacing stays 5.
  - `start`+`abort` together in IDLE → no `frame_trig`.
  - `start` on the `done` cycle → `frame_trig` the next cycle.
- `rst`@22 during the first-case frame → all outputs 0@23. After deassert, `start` → a normal frame with `line_idx` starting at 0.
